fp_accum: RTL and testbench

FP_ACCUM -- requirements
Module: fp_accum

---
 rtl/fp_accum.sv | 159 +++++++++++++++
 tb/tb_fp_accum.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accum.sv
// rtl/fp_accum.sv - multi-cycle fp32 accumulator summing LEN products per result
// Optional: define FP_ACCUM_SAT_EN to saturate exponent overflow instead of wrapping.
module fp_accum #(
  parameter int XLEN = 32,
  parameter int LEN  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

  localparam logic [7:0] LEN_W = 8'(LEN);

  state_t          state;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] opnd;
  logic [7:0]      count;
  logic [23:0]     man_big;
  logic [23:0]     man_small;
  logic [7:0]      exp_big;
  logic            sign_big;
  logic            sign_small;
  logic [24:0]     sum;
  logic            sum_sign;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) lzc24 = 5'(23 - i);
    end
  endfunction

  // A zero exponent drops the hidden bit, so zero operands fall out of the normal alignment path.
  logic [7:0]  ea, eb, diff;
  logic [23:0] ma, mb, shifted;
  logic        a_big;

  always_comb begin
    ea      = acc[30:23];
    eb      = opnd[30:23];
    ma      = {|ea, acc[22:0]};
    mb      = {|eb, opnd[22:0]};
    a_big   = (ea >= eb);
    diff    = a_big ? (ea - eb) : (eb - ea);
    shifted = (diff >= 8'd25) ? 24'd0 : ((a_big ? mb : ma) >> diff);
  end

  logic [4:0]        lz;
  logic signed [9:0] norm_exp;
  logic [23:0]       norm_man;
  logic [31:0]       norm_word;

  always_comb begin
    lz = lzc24(sum[23:0]);
    if (sum[24]) begin
      norm_man = sum[24:1];
      norm_exp = $signed({2'b00, exp_big}) + 10'sd1;
    end else begin
      norm_man = sum[23:0] << lz;
      norm_exp = $signed({2'b00, exp_big}) - $signed({5'b00000, lz});
    end
    if (sum == 25'd0 || norm_exp <= 10'sd0)
      norm_word = 32'd0;
`ifdef FP_ACCUM_SAT_EN
    else if (norm_exp > 10'sd254)
      norm_word = {sum_sign, 8'hFE, 23'h7FFFFF};
`endif
    else
      norm_word = {sum_sign, norm_exp[7:0], norm_man[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      opnd       <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      man_big    <= '0;
      man_small  <= '0;
      exp_big    <= '0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      sum        <= '0;
      sum_sign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd  <= in_data;
            count <= count + 8'd1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (a_big) begin
            man_big    <= ma;
            man_small  <= shifted;
            exp_big    <= ea;
            sign_big   <= acc[31];
            sign_small <= opnd[31];
          end else begin
            man_big    <= mb;
            man_small  <= shifted;
            exp_big    <= eb;
            sign_big   <= opnd[31];
            sign_small <= acc[31];
          end
          state <= ADD;
        end
        ADD: begin
          if (sign_big == sign_small) begin
            sum      <= {1'b0, man_big} + {1'b0, man_small};
            sum_sign <= sign_big;
          end else if (man_big >= man_small) begin
            sum      <= {1'b0, man_big - man_small};
            sum_sign <= sign_big;
          end else begin
            sum      <= {1'b0, man_small - man_big};
            sum_sign <= sign_small;
          end
          state <= NORM;
        end
        NORM: begin
          acc <= norm_word;
          if (count < LEN_W) begin
            state <= IDLE;
          end else begin
            out_data  <= norm_word;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fp_accum.sv
// tb/tb_fp_accum.sv - self-checking bench for fp_accum with a protocol-level reference model
module tb_fp_accum;
  localparam int LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy;

  fp_accum #(.XLEN(32), .LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_acc;
  int          m_cnt = 0;
  int          m_busy_left = 0;
  bit          m_done = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_out = 32'd0;
  int          n_out = 0;

`ifdef FP_ACCUM_SAT_EN
  localparam logic [31:0] OVF_RESULT = 32'h7F7FFFFF;
`else
  localparam logic [31:0] OVF_RESULT = 32'h7FFFFFFF;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  // Exact-value reference: scale both operands to the larger exponent as signed integers.
  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, p, en;
    longint ma, mb, r, mag;
    bit s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 64'sd0 : 64'({1'b1, a[22:0]});
    mb = (eb == 0) ? 64'sd0 : 64'({1'b1, b[22:0]});
    e  = (ea > eb) ? ea : eb;
    ma = (e - ea >= 25) ? 64'sd0 : (ma >> (e - ea));
    mb = (e - eb >= 25) ? 64'sd0 : (mb >> (e - eb));
    if (a[31]) ma = -ma;
    if (b[31]) mb = -mb;
    r = ma + mb;
    if (r == 0) return 32'd0;
    s   = (r < 0);
    mag = s ? -r : r;
    p = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) p = i;
    en = e + p - 23;
    if (p >= 23) mag = mag >> (p - 23);
    else         mag = mag << (23 - p);
    if (en <= 0) return 32'd0;
`ifdef FP_ACCUM_SAT_EN
    if (en > 254) return {s, 8'hFE, 23'h7FFFFF};
`endif
    return {s, en[7:0], mag[22:0]};
  endfunction

  initial begin
    m_acc = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        m_acc = 32'd0; m_cnt = 0; m_busy_left = 0; m_done = 0;
        exp_q.delete();
      end else if (m_busy_left > 0) begin
        check("proc_in_ready", 32'(in_ready), 32'd0);
        check("proc_out_valid", 32'(out_valid), 32'd0);
        check("proc_busy", 32'(busy), 32'd1);
        m_busy_left--;
      end else if (m_done) begin
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_in_ready", 32'(in_ready), 32'd0);
        check("out_busy", 32'(busy), 32'd1);
        check("out_data", out_data, exp_q[0]);
        if (out_ready) begin
          last_out = out_data;
          n_out++;
          void'(exp_q.pop_front());
          m_done = 0;
        end
      end else begin
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        if (in_valid) begin
          m_acc = m_add(m_acc, in_data);
          m_cnt++;
          m_busy_left = 3;
          if (m_cnt == LEN) begin
            exp_q.push_back(m_acc);
            m_acc = 32'd0;
            m_cnt = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] word);
    int t;
    bit ok;
    t = 0; ok = 0;
    in_valid = 1'b1;
    in_data = word;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_out(input string name, input logic [31:0] expv);
    int t, n0;
    t = 0; n0 = n_out;
    while (n_out == n0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    check({name, "_done"}, 32'(n_out - n0), 32'd1);
    check(name, last_out, expv);
  endtask

  task automatic run_group(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3, input logic [31:0] expv, input string name);
    send(w0); send(w1); send(w2); send(w3);
    wait_out(name, expv);
  endtask

  function automatic logic [31:0] rand_fp();
    int r;
    logic [7:0] e;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 32'd0;
    if (r == 1) return {1'($urandom), 8'd0, 23'($urandom)};
    if (r == 2) e = 8'($urandom_range(250, 255));
    else        e = 8'($urandom_range(100, 140));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    summary();
    $finish;
  end

  initial begin
    int t, n0;
    logic [31:0] d0;

    check("pin_sum", m_add(m_add(m_add(m_add(32'd0, 32'h3F800000), 32'h40000000), 32'h40400000), 32'h40800000), 32'h41200000);
    check("pin_cancel", m_add(32'h3F800000, 32'hBF800000), 32'd0);
    check("pin_drop", m_add(32'h4B800000, 32'h3F800000), 32'h4B800000);
    check("pin_ovf", m_add(m_add(32'h7F7FFFFF, 32'h7F7FFFFF), 32'd0), OVF_RESULT);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    run_group(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000, "sum10");
    run_group(32'h3F800000, 32'hBF800000, 32'h00000000, 32'h00000000, 32'h00000000, "cancel");
    run_group(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h00000000, OVF_RESULT, "overflow");
    run_group(32'h4B800000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h4B800000, "align_drop");

    // Backpressure: five cycles of out_ready low, handshake on the sixth.
    out_ready = 1'b0;
    send(32'h3F800000); send(32'h40000000); send(32'h40400000); send(32'h40800000);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 50);
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    d0 = out_data;
    check("bp_data", d0, 32'h41200000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_stable", out_data, 32'h41200000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp_after_in_ready", 32'(in_ready), 32'd1);
    check("bp_after_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset while element 3 is in ADD.
    send(32'h3F000000); send(32'h3F000000); send(32'h3F000000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    run_group(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40000000, "after_reset");

    // Randomized traffic with random gaps and backpressure.
    n0 = n_out;
    t = 0;
    while (n_out < n0 + 40 && t < 8000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_fp();
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
      t++;
    end
    check("random_outputs", 32'(n_out >= n0 + 40), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    summary();
    $finish;
  end
endmodule
